// File: rtl/ultras_pkg.sv
// rtl/ultras_pkg.sv - shared state type, default timing constants and helpers for the ultrasonic scheduler
package ultras_pkg;

    localparam int ULTRAS_CNT_W        = 21;
    localparam int ULTRAS_TRIG_CYCLES  = 500;
    localparam int ULTRAS_ECHO_TIMEOUT = 1_200_000;
    localparam int ULTRAS_GAP_CYCLES   = 3_000_000;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE,
        GAP
    } ultras_state_t;

    function automatic int ultras_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int ultras_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ultras_echo_sync.sv
// rtl/ultras_echo_sync.sv - echo sampling and rise detection; 2-flop synchronizer only with ULTRAS_ECHO_SYNC_EN
module ultras_echo_sync #(
    parameter int N     = 3,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     echo,
    input  logic [SEL_W-1:0] sel,
    output logic             level,
    output logic             rise
);

    logic [N-1:0] sampled;
    logic [N-1:0] prev;

`ifdef ULTRAS_ECHO_SYNC_EN
    logic [N-1:0] meta;
    logic [N-1:0] stable;

    // Two-flop synchronizer per echo bit for pins asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= '0;
            stable <= '0;
        end else begin
            meta   <= echo;
            stable <= meta;
        end
    end

    assign sampled = stable;
`else
    assign sampled = echo;
`endif

    // Previous sample of every channel, so a freshly selected channel already has history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= sampled;
        end
    end

    assign level = sampled[sel];
    assign rise  = sampled[sel] & ~prev[sel];

endmodule

// File: rtl/ultras_scheduler.sv
// rtl/ultras_scheduler.sv - round-robin ultrasonic trigger/echo sequencer; optional ULTRAS_ECHO_SYNC_EN
module ultras_scheduler
    import ultras_pkg::*;
#(
    parameter int N_SENSORS    = 3,
    parameter int CNT_W        = ULTRAS_CNT_W,
    parameter int TRIG_CYCLES  = ULTRAS_TRIG_CYCLES,
    parameter int ECHO_TIMEOUT = ULTRAS_ECHO_TIMEOUT,
    parameter int GAP_CYCLES   = ULTRAS_GAP_CYCLES,
    localparam int SEL_W       = ultras_sel_w(N_SENSORS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic                 busy,
    output logic                 result_valid,
    output logic [SEL_W-1:0]     result_sensor,
    output logic [CNT_W-1:0]     result_width,
    output logic                 result_timeout
);

    // The phase counter is widened beyond CNT_W when needed so the default gap length fits
    localparam int PHASE_W = ultras_max(CNT_W,
                             ultras_max($clog2(GAP_CYCLES + 1),
                             ultras_max($clog2(ECHO_TIMEOUT + 1), $clog2(TRIG_CYCLES + 1))));

    localparam logic [PHASE_W-1:0] TRIG_LAST = PHASE_W'(TRIG_CYCLES - 1);
    localparam logic [PHASE_W-1:0] TO_LAST   = PHASE_W'(ECHO_TIMEOUT - 1);
    localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(GAP_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(N_SENSORS - 1);

    ultras_state_t      state;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   sel_next;
    logic [PHASE_W-1:0] cnt;
    logic [CNT_W-1:0]   width;
    logic [CNT_W-1:0]   width_inc;
    logic               echo_level;
    logic               echo_rise;

    function automatic logic [N_SENSORS-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [N_SENSORS-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    ultras_echo_sync #(
        .N     (N_SENSORS),
        .SEL_W (SEL_W)
    ) u_echo_sync (
        .clk   (clk),
        .rst   (rst),
        .echo  (echo),
        .sel   (sel),
        .level (echo_level),
        .rise  (echo_rise)
    );

    assign sel_next  = (sel == SEL_LAST) ? '0 : sel + 1'b1;
    assign width_inc = (&width) ? width : width + 1'b1;
    assign busy      = (state != IDLE);

    // Measurement FSM with the shared phase counter and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sel            <= '0;
            cnt            <= '0;
            width          <= '0;
            trig           <= '0;
            result_valid   <= 1'b0;
            result_sensor  <= '0;
            result_width   <= '0;
            result_timeout <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= TRIG;
                        trig  <= onehot(sel);
                        cnt   <= '0;
                    end
                end
                TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state <= WAIT_RISE;
                        trig  <= '0;
                        cnt   <= '0;
                        width <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == TO_LAST) begin
                        state          <= DONE;
                        result_valid   <= 1'b1;
                        result_sensor  <= sel;
                        result_width   <= width;
                        result_timeout <= 1'b1;
                    end else if (echo_rise) begin
                        state <= MEASURE;
                        width <= CNT_W'(1);
                    end
                end
                MEASURE: begin
                    cnt <= cnt + 1'b1;
                    if (!echo_level) begin
                        state          <= DONE;
                        result_valid   <= 1'b1;
                        result_sensor  <= sel;
                        result_width   <= width;
                        result_timeout <= 1'b0;
                    end else if (cnt == TO_LAST) begin
                        state          <= DONE;
                        result_valid   <= 1'b1;
                        result_sensor  <= sel;
                        result_width   <= width_inc;
                        result_timeout <= 1'b1;
                    end else begin
                        width <= width_inc;
                    end
                end
                DONE: begin
                    state <= GAP;
                    cnt   <= '0;
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        sel <= sel_next;
                        cnt <= '0;
                        if (enable) begin
                            state <= TRIG;
                            trig  <= onehot(sel_next);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    trig  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultras_scheduler.sv
// tb/tb_ultras_scheduler.sv - self-checking bench for ultras_scheduler with a pulse-level reference model
module tb_ultras_scheduler;

    localparam int N     = 3;
    localparam int TRIGC = 4;
    localparam int TO    = 50;
    localparam int GAP   = 8;
    localparam int CW    = 21;
`ifdef ULTRAS_ECHO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [N-1:0]  echo;
    logic [N-1:0]  trig;
    logic          busy;
    logic          result_valid;
    logic [1:0]    result_sensor;
    logic [CW-1:0] result_width;
    logic          result_timeout;

    int checks  = 0;
    int errors  = 0;
    int cur_sel = 0;

    always #5 clk = ~clk;

    ultras_scheduler #(
        .N_SENSORS    (N),
        .CNT_W        (CW),
        .TRIG_CYCLES  (TRIGC),
        .ECHO_TIMEOUT (TO),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .echo           (echo),
        .trig           (trig),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_sensor  (result_sensor),
        .result_width   (result_width),
        .result_timeout (result_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One measurement on the currently expected sensor. The echo pin of that sensor is high
    // for negedges s..s+len-1 counted from trigger fall (len=0: never). pre_high holds it high
    // from before the trigger ends. drop_en lowers enable while the echo is being measured.
    task automatic run_meas(input int s, input int len, input bit pre_high, input bit drop_en);
        int jr, jf, jd, exp_w, exp_to, n, got, zeros, high_cnt;
        logic [N-1:0] exp_trig;
        logic v;
        exp_trig          = '0;
        exp_trig[cur_sel] = 1'b1;
        jr = s + 1 + LAT;
        jf = s + len + LAT + 1;
        if (pre_high || len == 0 || jr >= TO) begin
            jd = TO; exp_w = 0; exp_to = 1;
        end else if (jf <= TO) begin
            jd = jf; exp_w = len; exp_to = 0;
        end else begin
            jd = TO; exp_w = TO - jr + 1; exp_to = 1;
        end
        if (pre_high) echo[cur_sel] = 1'b1;
        n = 0;
        while (trig === '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("trig_start", 32'(trig !== '0), 1);
        high_cnt = 0;
        while (trig !== '0 && high_cnt < 50) begin
            check("trig_onehot", 32'(trig), 32'(exp_trig));
            high_cnt++;
            @(negedge clk);
        end
        check("trig_len", high_cnt, TRIGC);
        check("busy_meas", 32'(busy), 1);
        got = -1;
        for (int i = 0; i <= TO + 10; i++) begin
            if (i > 0) @(negedge clk);
            if (result_valid === 1'b1) begin
                got = i;
                break;
            end
            for (int b = 0; b < N; b++) begin
                if (b == cur_sel) v = pre_high | (i >= s && i < s + len);
                else v = 1'($urandom_range(0, 1));
                echo[b] = v;
            end
            if (drop_en && i == s + LAT + 2) enable = 1'b0;
        end
        check("result_latency", got, jd);
        check("result_sensor", 32'(result_sensor), cur_sel);
        check("result_width", 32'(result_width), exp_w);
        check("result_timeout", 32'(result_timeout), exp_to);
        echo = '0;
        @(negedge clk);
        check("result_pulse", 32'(result_valid), 0);
        check("result_hold", 32'(result_width), exp_w);
        cur_sel = (cur_sel + 1) % N;
        zeros = 0;
        while (trig === '0 && zeros < GAP + 20) begin
            zeros++;
            @(negedge clk);
        end
        if (enable) begin
            check("gap_len", zeros, GAP);
        end else begin
            check("idle_no_trig", zeros, GAP + 20);
            check("idle_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        enable = 1'b0;
        echo   = '0;
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_sensor", 32'(result_sensor), 0);
        check("rst_width", 32'(result_width), 0);
        check("rst_timeout", 32'(result_timeout), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy_disabled", 32'(busy), 0);
        check("idle_trig_disabled", 32'(trig), 0);

        enable = 1'b1;
        run_meas(5, 10, 1'b0, 1'b0);
        run_meas(0, 0, 1'b0, 1'b0);
        run_meas(0, 60, 1'b0, 1'b0);

        run_meas(4, 3, 1'b0, 1'b0);
        run_meas(4, 6, 1'b0, 1'b0);
        run_meas(4, 9, 1'b0, 1'b0);
        run_meas(4, 3, 1'b0, 1'b0);

        run_meas(0, 0, 1'b1, 1'b0);

        repeat (6) run_meas($urandom_range(0, 45), $urandom_range(1, 60), 1'b0, 1'b0);

        run_meas(3, 8, 1'b0, 1'b1);
        enable = 1'b1;
        while (cur_sel != 2) run_meas($urandom_range(0, 20), $urandom_range(1, 20), 1'b0, 1'b0);

        n = 0;
        while (trig === '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rst_pre_trig", 32'(trig), 32'h4);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_async_trig", 32'(trig), 0);
        check("rst_async_busy", 32'(busy), 0);
        enable = 1'b0;
        echo   = '0;
        @(negedge clk);
        rst     = 1'b0;
        cur_sel = 0;
        check("rst_clear_width", 32'(result_width), 0);
        check("rst_clear_sensor", 32'(result_sensor), 0);
        @(negedge clk);
        enable = 1'b1;
        run_meas(3, 5, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
